// File: rtl/gpr_writeback_arbiter.sv
// gpr_writeback_arbiter
//   Shares the single GPR write port between NREQ writeback requesters
//   using valid/ready handshakes and round-robin arbitration. The accepted
//   request is registered and presented on the write port one cycle later.
//   Writes to register 0 complete the handshake but never raise write_enable.
//
// Parameters: NREQ (2..8), DATA_W, ADDR_W
// Ports:
//   clk, reset_n              clock, async active-low reset
//   rf_hold                   suppress all grants this cycle
//   req_valid/addr/data       flattened per-requester request (slice i)
//   req_ready                 one-hot grant, combinational
//   write_enable/write/write_data  registered register-file write port
//   last_grant                index of the most recently accepted requester
//   byp_read*/byp_in*/byp_out*     read-data bypass around the write port
//
// Optional feature: define WB_BYPASS_EN to forward the pending write into
// byp_out1/byp_out2; otherwise the read data passes straight through.
module gpr_writeback_arbiter #(
    parameter int NREQ   = 3,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     rf_hold,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*ADDR_W-1:0]   req_addr,
    input  logic [NREQ*DATA_W-1:0]   req_data,
    output logic [NREQ-1:0]          req_ready,
    output logic                     write_enable,
    output logic [ADDR_W-1:0]        write,
    output logic [DATA_W-1:0]        write_data,
    output logic [2:0]               last_grant,
    input  logic [ADDR_W-1:0]        byp_read1,
    input  logic [ADDR_W-1:0]        byp_read2,
    input  logic [DATA_W-1:0]        byp_in1,
    input  logic [DATA_W-1:0]        byp_in2,
    output logic [DATA_W-1:0]        byp_out1,
    output logic [DATA_W-1:0]        byp_out2
);
    localparam int PTR_W = 3;

    logic [NREQ-1:0][ADDR_W-1:0] addr_a;
    logic [NREQ-1:0][DATA_W-1:0] data_a;

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign addr_a[i] = req_addr[i*ADDR_W +: ADDR_W];
        assign data_a[i] = req_data[i*DATA_W +: DATA_W];
    end

    logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]  last_grant_q, last_grant_d;
    logic              write_enable_q, write_enable_d;
    logic [ADDR_W-1:0] write_q, write_d;
    logic [DATA_W-1:0] write_data_q, write_data_d;

    logic [PTR_W-1:0]  gnt_idx;
    logic              gnt_found;
    logic              accept;
    logic [NREQ-1:0]   gnt_oh;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;

    // Round-robin search as two linear passes: first the requesters at or
    // above the pointer, then the wrapped-around ones below it.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!gnt_found && req_valid[i] && (PTR_W'(i) >= rr_ptr_q)) begin
                gnt_found = 1'b1;
                gnt_idx   = PTR_W'(i);
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!gnt_found && req_valid[i] && (PTR_W'(i) < rr_ptr_q)) begin
                gnt_found = 1'b1;
                gnt_idx   = PTR_W'(i);
            end
        end
    end

    // reset_n gates the grant so req_ready is 0 while reset is held.
    assign accept = gnt_found && !rf_hold && reset_n;

    always_comb begin
        gnt_oh   = '0;
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            gnt_oh[i] = accept && (gnt_idx == PTR_W'(i));
            if (gnt_oh[i]) begin
                sel_addr = addr_a[i];
                sel_data = data_a[i];
            end
        end
    end

    assign req_ready = gnt_oh;

    always_comb begin
        rr_ptr_d       = rr_ptr_q;
        last_grant_d   = last_grant_q;
        write_d        = write_q;
        write_data_d   = write_data_q;
        write_enable_d = 1'b0;
        if (accept) begin
            rr_ptr_d       = (gnt_idx == PTR_W'(NREQ - 1)) ? '0 : gnt_idx + PTR_W'(1);
            last_grant_d   = gnt_idx;
            write_d        = sel_addr;
            write_data_d   = sel_data;
            write_enable_d = (sel_addr != '0);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr_q       <= '0;
            last_grant_q   <= '0;
            write_enable_q <= 1'b0;
            write_q        <= '0;
            write_data_q   <= '0;
        end else begin
            rr_ptr_q       <= rr_ptr_d;
            last_grant_q   <= last_grant_d;
            write_enable_q <= write_enable_d;
            write_q        <= write_d;
            write_data_q   <= write_data_d;
        end
    end

    assign write_enable = write_enable_q;
    assign write        = write_q;
    assign write_data   = write_data_q;
    assign last_grant   = last_grant_q;

`ifdef WB_BYPASS_EN
    // Covers the cycle between acceptance and the register-file update.
    assign byp_out1 = (write_enable_q && (write_q == byp_read1) && (byp_read1 != '0))
                      ? write_data_q : byp_in1;
    assign byp_out2 = (write_enable_q && (write_q == byp_read2) && (byp_read2 != '0))
                      ? write_data_q : byp_in2;
`else
    logic unused_byp_read;
    assign unused_byp_read = ^{byp_read1, byp_read2};
    assign byp_out1 = byp_in1;
    assign byp_out2 = byp_in2;
`endif

endmodule

// File: tb/tb_gpr_writeback_arbiter.sv
module tb_gpr_writeback_arbiter;
    localparam int NREQ   = 3;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    logic                   clk = 1'b0;
    logic                   reset_n = 1'b0;
    logic                   rf_hold = 1'b0;
    logic [NREQ-1:0]        req_valid = '0;
    logic [NREQ*ADDR_W-1:0] req_addr = '0;
    logic [NREQ*DATA_W-1:0] req_data = '0;
    logic [NREQ-1:0]        req_ready;
    logic                   write_enable;
    logic [ADDR_W-1:0]      write;
    logic [DATA_W-1:0]      write_data;
    logic [2:0]             last_grant;
    logic [ADDR_W-1:0]      byp_read1 = '0, byp_read2 = '0;
    logic [DATA_W-1:0]      byp_in1 = '0, byp_in2 = '0;
    logic [DATA_W-1:0]      byp_out1, byp_out2;

    gpr_writeback_arbiter #(.NREQ(NREQ), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset_n(reset_n), .rf_hold(rf_hold),
        .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
        .req_ready(req_ready), .write_enable(write_enable), .write(write),
        .write_data(write_data), .last_grant(last_grant),
        .byp_read1(byp_read1), .byp_read2(byp_read2),
        .byp_in1(byp_in1), .byp_in2(byp_in2),
        .byp_out1(byp_out1), .byp_out2(byp_out2)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: pointer as an integer, write port as plain variables.
    int                m_ptr;
    int                m_last;
    logic              m_we;
    logic [ADDR_W-1:0] m_waddr;
    logic [DATA_W-1:0] m_wdata;

    task automatic model_reset();
        m_ptr = 0; m_last = 0; m_we = 1'b0; m_waddr = '0; m_wdata = '0;
    endtask

    function automatic int model_grant();
        if (rf_hold) return -1;
        for (int k = 0; k < NREQ; k++) begin
            int idx;
            idx = (m_ptr + k) % NREQ;
            if (req_valid[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic logic [DATA_W-1:0] exp_byp(input logic [ADDR_W-1:0] rd,
                                                  input logic [DATA_W-1:0] din);
`ifdef WB_BYPASS_EN
        if (m_we && m_waddr == rd && rd != 0) return m_wdata;
`endif
        return din;
    endfunction

    function automatic logic [NREQ-1:0] onehot(input int g);
        logic [NREQ-1:0] v;
        v = '0;
        if (g >= 0) v[g] = 1'b1;
        return v;
    endfunction

    // One clock of model-checked operation. Inputs are set at posedge+1 by
    // the caller; combinational outputs checked at posedge+2, registers at
    // the following posedge+1.
    task automatic step(input string tag, output int g);
        #1;
        g = model_grant();
        chk({tag, " req_ready"}, req_ready, onehot(g));
        chk({tag, " byp_out1"}, byp_out1, exp_byp(byp_read1, byp_in1));
        chk({tag, " byp_out2"}, byp_out2, exp_byp(byp_read2, byp_in2));
        @(posedge clk);
        if (g >= 0) begin
            m_ptr   = (g + 1) % NREQ;
            m_last  = g;
            m_waddr = req_addr[g*ADDR_W +: ADDR_W];
            m_wdata = req_data[g*DATA_W +: DATA_W];
            m_we    = (m_waddr != 0);
        end else begin
            m_we = 1'b0;
        end
        #1;
        chk({tag, " write_enable"}, write_enable, m_we);
        chk({tag, " write"}, write, m_waddr);
        chk({tag, " write_data"}, write_data, m_wdata);
        chk({tag, " last_grant"}, last_grant, m_last[2:0]);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " write_enable"}, write_enable, 0);
        chk({tag, " write"}, write, 0);
        chk({tag, " write_data"}, write_data, 0);
        chk({tag, " last_grant"}, last_grant, 0);
        chk({tag, " req_ready"}, req_ready, 0);
    endtask

    // Called at posedge+1; holds reset across one edge, releases at posedge+1.
    task automatic do_reset(input string tag);
        reset_n = 1'b0;
        #1;
        chk_all_zero(tag);
        model_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic set_req(input int i, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        req_addr[i*ADDR_W +: ADDR_W] = a;
        req_data[i*DATA_W +: DATA_W] = d;
    endtask

    typedef struct {
        logic            hold;
        logic [NREQ-1:0] valid;
        logic [NREQ-1:0] rdy;
        logic            we;
        logic [4:0]      wa;
        logic [2:0]      lg;
    } vec_t;

    vec_t tbl[14];

    logic              r_v[NREQ];
    logic [ADDR_W-1:0] r_a[NREQ];
    logic [DATA_W-1:0] r_d[NREQ];

    initial begin
        int g;

        // Requester i writes addr i+1, data C0DE0000+i; wdata derived from wa.
        tbl[0]  = '{1'b0, 3'b111, 3'b001, 1'b1, 5'd1, 3'd0};
        tbl[1]  = '{1'b0, 3'b111, 3'b010, 1'b1, 5'd2, 3'd1};
        tbl[2]  = '{1'b0, 3'b111, 3'b100, 1'b1, 5'd3, 3'd2};
        tbl[3]  = '{1'b0, 3'b111, 3'b001, 1'b1, 5'd1, 3'd0};
        tbl[4]  = '{1'b0, 3'b111, 3'b010, 1'b1, 5'd2, 3'd1};
        tbl[5]  = '{1'b0, 3'b111, 3'b100, 1'b1, 5'd3, 3'd2};
        tbl[6]  = '{1'b1, 3'b111, 3'b000, 1'b0, 5'd3, 3'd2};
        tbl[7]  = '{1'b1, 3'b111, 3'b000, 1'b0, 5'd3, 3'd2};
        tbl[8]  = '{1'b1, 3'b111, 3'b000, 1'b0, 5'd3, 3'd2};
        tbl[9]  = '{1'b0, 3'b111, 3'b001, 1'b1, 5'd1, 3'd0};
        tbl[10] = '{1'b0, 3'b100, 3'b100, 1'b1, 5'd3, 3'd2};
        tbl[11] = '{1'b0, 3'b011, 3'b001, 1'b1, 5'd1, 3'd0};
        tbl[12] = '{1'b0, 3'b000, 3'b000, 1'b0, 5'd1, 3'd0};
        tbl[13] = '{1'b0, 3'b110, 3'b010, 1'b1, 5'd2, 3'd1};

        // Reset held with a request pending: ready must stay low.
        req_valid = 3'b111;
        @(posedge clk);
        #1;
        do_reset("rst0");

        // First request after reset, then reset asserted mid-cycle with write pending.
        req_valid = 3'b001;
        set_req(0, 5'd5, 32'hDEADBEEF);
        step("first", g);
        chk("first write const", write, 5);
        chk("first data const", write_data, 32'hDEADBEEF);
        set_req(0, 5'd9, 32'h0BADF00D);
        #1;
        chk("pre-rst write_enable", write_enable, 1);
        #1;
        do_reset("rst_mid");

        // Directed table: fairness, hold, partial valids.
        for (int i = 0; i < NREQ; i++) set_req(i, ADDR_W'(i + 1), 32'hC0DE0000 + i);
        for (int i = 0; i < 14; i++) begin
            rf_hold   = tbl[i].hold;
            req_valid = tbl[i].valid;
            #1;
            chk($sformatf("tbl%0d req_ready", i), req_ready, tbl[i].rdy);
            @(posedge clk);
            #1;
            chk($sformatf("tbl%0d write_enable", i), write_enable, tbl[i].we);
            chk($sformatf("tbl%0d write", i), write, tbl[i].wa);
            chk($sformatf("tbl%0d write_data", i), write_data, 32'hC0DE0000 + tbl[i].wa - 1);
            chk($sformatf("tbl%0d last_grant", i), last_grant, tbl[i].lg);
        end
        rf_hold = 1'b0;
        req_valid = '0;

        // Register zero: requester 1 writes r0, then requester 2 is next.
        do_reset("rst_r0");
        for (int i = 0; i < NREQ; i++) set_req(i, ADDR_W'(i + 4), 32'h7700 + i);
        req_valid = 3'b001;
        step("r0a", g);
        set_req(1, 5'd0, 32'h1234);
        req_valid = 3'b110;
        step("r0b", g);
        chk("r0 grant", g, 1);
        chk("r0 write_enable low", write_enable, 0);
        req_valid = 3'b111;
        step("r0c", g);
        chk("r0 next grant", last_grant, 2);

        // Bypass window right after acceptance.
        do_reset("rst_byp");
        req_valid = 3'b001;
        set_req(0, 5'd7, 32'hA5A5A5A5);
        step("byp_acc", g);
        req_valid = '0;
        byp_read1 = 5'd7; byp_in1 = 32'h0;
        byp_read2 = 5'd0; byp_in2 = 32'h55551111;
        #1;
`ifdef WB_BYPASS_EN
        chk("byp1 fwd", byp_out1, 32'hA5A5A5A5);
`else
        chk("byp1 pass", byp_out1, 32'h0);
`endif
        chk("byp2 r0", byp_out2, 32'h55551111);
        step("byp_after", g);

        // Randomized traffic against the model, requests kept stable until taken.
        do_reset("rst_rnd");
        for (int i = 0; i < NREQ; i++) begin
            r_v[i] = 1'b0; r_a[i] = '0; r_d[i] = '0;
        end
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!r_v[i]) begin
                    r_v[i] = ($urandom_range(0, 3) != 0);
                    r_a[i] = ADDR_W'($urandom_range(0, 7));
                    r_d[i] = $urandom;
                end else if ($urandom_range(0, 15) == 0) begin
                    r_v[i] = 1'b0;
                end
                req_valid[i] = r_v[i];
                set_req(i, r_a[i], r_d[i]);
            end
            rf_hold   = ($urandom_range(0, 4) == 0);
            byp_read1 = ADDR_W'($urandom_range(0, 7));
            byp_read2 = ADDR_W'($urandom_range(0, 7));
            byp_in1   = $urandom;
            byp_in2   = $urandom;
            step($sformatf("rnd%0d", c), g);
            if (g >= 0) r_v[g] = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gpr_writeback_arbiter.md
# gpr_writeback_arbiter

Shares the single GPR write port between several writeback requesters (ALU, load unit, multiply/divide unit) using valid/ready handshakes and round-robin arbitration. Exactly one accepted request per cycle is registered and driven onto the register-file write port (`write_enable`, `write`, `write_data`) on the following cycle. Requests to register 0 complete their handshake but never assert the write port.

## Interface
- `NREQ`, 3: number of requesters; legal range 2..8.
- `DATA_W`, 32: write-data width.
- `ADDR_W`, 5: register-address width.

- `clk`  in  1  clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `rf_hold`  in  1  when high, no new grants are issued.
- `req_valid`  in  NREQ  per-requester request valid.
- `req_addr`  in  NREQ*ADDR_W  destination register; requester i uses slice [i*ADDR_W +: ADDR_W].
- `req_data`  in  NREQ*DATA_W  write data; requester i uses slice [i*DATA_W +: DATA_W].
- `req_ready`  out  NREQ  one-hot or zero grant; combinational.
- `write_enable`  out  1  registered register-file write enable.
- `write`  out  ADDR_W  registered register-file write address.
- `write_data`  out  DATA_W  registered register-file write data.
- `last_grant`  out  3  index of the most recently accepted requester.
- `byp_read1`, `byp_read2`  in  ADDR_W  read addresses presented to the register file.
- `byp_in1`, `byp_in2`  in  DATA_W  register-file read data.
- `byp_out1`, `byp_out2`  out  DATA_W  read data after bypass (see Configuration).

## Operation
- **Round-robin pointer `rr_ptr`** (0..NREQ-1): the search for a grant starts at `rr_ptr` and wraps modulo NREQ. The first requester with valid high is granted.
- **Grant conditions:** `req_ready[i]` is high only for the granted i, and only when `rf_hold` is low. When `rf_hold` is high, or no requester is valid, `req_ready` is 0.
- **Acceptance:** a handshake occurs when `req_valid[i] & req_ready[i]`. On acceptance:
  - `rr_ptr` becomes (i+1) mod NREQ.
  - `last_grant` becomes i.
  - `write` and `write_data` capture requester i's slices.
  - `write_enable` becomes 1 if the address is nonzero, otherwise 0.
- **No acceptance:** `write_enable` is 0 the next cycle. `write` and `write_data` hold their previous values.
- **Requester obligation:** `req_valid`, `req_addr` and `req_data` stay stable until accepted. Dropping valid before acceptance is legal; the request is simply withdrawn.
- **Fairness:** with all NREQ requesters continuously valid, grants rotate 0,1,2,0,… Any continuously valid requester is granted within NREQ cycles of `rf_hold` being low.
- **Reset (`reset_n` low):** `rr_ptr`=0, `write_enable`=0, `write`=0, `write_data`=0, `last_grant`=0, `req_ready`=0. This takes effect immediately, including mid-operation. An in-flight registered write is discarded: `write_enable` falls asynchronously.

## Timing
- **Accept to write-port:** accept at edge N → `write_enable` high during cycle N..N+1 → register file updates at edge N+1.
- **Throughput:** one write per cycle. Back-to-back grants produce consecutive `write_enable` pulses.
- **`rf_hold`:** asserted in cycle N suppresses grants in cycle N (combinational). Therefore `write_enable` is 0 in cycle N+1.
- **Reset release:** the first grant is possible in the first cycle after `reset_n` rises, subject to the usual setup requirement.
- **Zero-address requests:** consume a grant slot and advance `rr_ptr`.

## Configuration
- **`WB_BYPASS_EN` defined:**
  - `byp_outK` = `write_data` when `write_enable` is high and `write` == `byp_readK` != 0.
  - Otherwise `byp_outK` = `byp_inK`.
  - Purely combinational; this covers the one-cycle window between acceptance and the register-file update.
- **`WB_BYPASS_EN` undefined:** `byp_outK` = `byp_inK` unconditionally. The ports remain present so integration is identical.

## Test plan
- **Reset values:** assert `reset_n`=0 mid-stream while `write_enable`=1 → all outputs 0 immediately. Release, then `req_valid`=3'b001, addr 5, data 0xDEADBEEF → `req_ready`=3'b001, and next cycle `write_enable`=1, `write`=5, `write_data`=0xDEADBEEF.
- **Fairness:** all three valid for 6 cycles with distinct addr 1/2/3 → grants 0,1,2,0,1,2, `last_grant` follows, and `write_enable` is high for 6 consecutive cycles.
- **Hold:** `rf_hold`=1 with all valid for 3 cycles → `req_ready`=0 and `write_enable`=0. Release → grant resumes at the pointer left before the hold.
- **Register zero:** requester 1 writes addr 0, data 0x1234 → handshake completes, `write_enable` stays 0, and next grant goes to requester 2 if it is valid.
- **Bypass:** accept addr 7, data 0xA5A5A5A5; in the next cycle `byp_read1`=7, `byp_in1`=0 → `byp_out1`=0xA5A5A5A5 with the macro, 0 without it. With `byp_read2`=0, `byp_out2`=`byp_in2` in both builds.
